// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, 32x32 regfile, immediate extend, D/E register (REGFILE_BYPASS_EN forwards same-cycle writeback).
// Latency: 1 cycle InstrD -> *_E outputs.
// Backpressure: none; captures every cycle, FlushE turns the captured slot into a bubble.
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        ResultSrcE,
    output logic        BranchE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Imm_Ext_E,
    output logic [4:0]  RD_E,
    output logic [4:0]  RS1_E,
    output logic [4:0]  RS2_E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E
);
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic        result_src;
        logic        branch;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } de_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic       funct7b5;

    assign opcode   = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign funct7b5 = InstrD[30];

    logic       reg_write, alu_src, mem_write, result_src, branch;
    logic [1:0] imm_src, alu_op;
    logic [2:0] alu_ctrl;
    logic [31:0] imm_ext, rd1, rd2;

    always_comb begin
        reg_write  = 1'b0;
        imm_src    = 2'b00;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = 1'b1; end
            OP_SW:   begin imm_src = 2'b01; alu_src = 1'b1; mem_write = 1'b1; end
            OP_R:    begin reg_write = 1'b1; alu_op = 2'b10; end
            OP_IALU: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
            OP_BEQ:  begin imm_src = 2'b10; branch = 1'b1; alu_op = 2'b01; end
            default: ;
        endcase
    end

    always_comb begin
        alu_ctrl = 3'b000;
        case (alu_op)
            2'b01: alu_ctrl = 3'b001;
            2'b10: begin
                case (funct3)
                    // opcode[5] separates R-type sub from I-type addi with imm bit 10 set
                    3'b000:  alu_ctrl = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl = 3'b101;
                    3'b110:  alu_ctrl = 3'b011;
                    3'b111:  alu_ctrl = 3'b010;
                    default: alu_ctrl = 3'b000;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        case (imm_src)
            2'b01:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        endcase
    end

    logic [31:0] rf_q [32];
    logic        wb_en;

    assign wb_en = RegWriteW && (RDW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[RDW] <= ResultW;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd1 = (rs1 == 5'd0) ? '0 : ((wb_en && RDW == rs1) ? ResultW : rf_q[rs1]);
    assign rd2 = (rs2 == 5'd0) ? '0 : ((wb_en && RDW == rs2) ? ResultW : rf_q[rs2]);
`else
    assign rd1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`endif

    de_t de_d, de_q;

    always_comb begin
        de_d.reg_write  = reg_write & ~FlushE;
        de_d.mem_write  = mem_write & ~FlushE;
        de_d.alu_src    = alu_src;
        de_d.result_src = result_src & ~FlushE;
        de_d.branch     = branch & ~FlushE;
        de_d.alu_ctrl   = alu_ctrl;
        de_d.rd1        = rd1;
        de_d.rd2        = rd2;
        de_d.imm        = imm_ext;
        de_d.rd         = FlushE ? 5'd0 : rd;
        de_d.rs1        = rs1;
        de_d.rs2        = rs2;
        de_d.pc         = PCD;
        de_d.pc_plus4   = PCPlus4D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) de_q <= '0;
        else      de_q <= de_d;
    end

    assign RegWriteE   = de_q.reg_write;
    assign MemWriteE   = de_q.mem_write;
    assign ALUSrcE     = de_q.alu_src;
    assign ResultSrcE  = de_q.result_src;
    assign BranchE     = de_q.branch;
    assign ALUControlE = de_q.alu_ctrl;
    assign RD1_E       = de_q.rd1;
    assign RD2_E       = de_q.rd2;
    assign Imm_Ext_E   = de_q.imm;
    assign RD_E        = de_q.rd;
    assign RS1_E       = de_q.rs1;
    assign RS2_E       = de_q.rs2;
    assign PCE         = de_q.pc;
    assign PCPlus4E    = de_q.pc_plus4;
endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed vector table, hand sequences for reset/writeback/flush, random vs reference model.
module tb_decode_cycle;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E, RS1_E, RS2_E;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    // ctrl = {RegWrite, MemWrite, ALUSrc, ResultSrc, Branch}
    typedef struct {
        logic [4:0]  ctrl;
        logic [2:0]  alu;
        logic [31:0] imm;
        logic        imm_chk;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        flush;
        exp_t        e;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mdl_rf [32];
    logic [31:0] pc_cnt = 32'h0000_1000;
    logic [31:0] exp_pc, exp_rd1, exp_rd2;
    vec_t vecs[$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] rs, input logic wen,
                                            input logic [4:0] wrd, input logic [31:0] wdata);
        if (rs == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wen && wrd == rs) return wdata;
`endif
        return mdl_rf[rs];
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic flush);
        exp_t e;
        logic is_lw, is_sw, is_r, is_i, is_b;
        is_lw = (i[6:0] == 7'h03);
        is_sw = (i[6:0] == 7'h23);
        is_r  = (i[6:0] == 7'h33);
        is_i  = (i[6:0] == 7'h13);
        is_b  = (i[6:0] == 7'h63);
        e.ctrl = {(is_lw | is_r | is_i) & ~flush, is_sw & ~flush, is_lw | is_sw | is_i,
                  is_lw & ~flush, is_b & ~flush};
        e.alu = 3'd0;
        if (is_b) e.alu = 3'd1;
        else if (is_r || is_i) begin
            case (i[14:12])
                3'd0: e.alu = (is_r && i[30]) ? 3'd1 : 3'd0;
                3'd2: e.alu = 3'd5;
                3'd6: e.alu = 3'd3;
                3'd7: e.alu = 3'd2;
                default: e.alu = 3'd0;
            endcase
        end
        if (is_sw)     e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        else if (is_b) e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        else           e.imm = {{20{i[31]}}, i[31:20]};
        e.imm_chk = !is_r;
        e.rd = flush ? 5'd0 : i[11:7];
        return e;
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic flush, input logic [4:0] ctrl,
                                input logic [2:0] alu, input logic [31:0] imm, input logic imm_chk,
                                input logic [4:0] rd);
        vec_t v;
        v.instr = instr; v.flush = flush;
        v.e.ctrl = ctrl; v.e.alu = alu; v.e.imm = imm; v.e.imm_chk = imm_chk; v.e.rd = rd;
        return v;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic flush, input logic wen,
                         input logic [4:0] wrd, input logic [31:0] wdata);
        InstrD = instr; PCD = pc_cnt; PCPlus4D = pc_cnt + 32'd4;
        FlushE = flush; RegWriteW = wen; RDW = wrd; ResultW = wdata;
        exp_pc  = pc_cnt;
        exp_rd1 = rf_read(instr[19:15], wen, wrd, wdata);
        exp_rd2 = rf_read(instr[24:20], wen, wrd, wdata);
        @(posedge clk);
        #1;
        if (wen && wrd != 5'd0) mdl_rf[wrd] = wdata;
        RegWriteW = 1'b0;
        pc_cnt = pc_cnt + 32'd4;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk32({tag, ".ctrl"}, {27'd0, RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, BranchE}, {27'd0, e.ctrl});
        chk32({tag, ".alu"}, {29'd0, ALUControlE}, {29'd0, e.alu});
        if (e.imm_chk) chk32({tag, ".imm"}, Imm_Ext_E, e.imm);
        chk32({tag, ".rd"}, {27'd0, RD_E}, {27'd0, e.rd});
        chk32({tag, ".rs"}, {22'd0, RS1_E, RS2_E}, {22'd0, InstrD[19:15], InstrD[24:20]});
        chk32({tag, ".rd1"}, RD1_E, exp_rd1);
        chk32({tag, ".rd2"}, RD2_E, exp_rd2);
        chk32({tag, ".pc"}, PCE, exp_pc);
        chk32({tag, ".pc4"}, PCPlus4E, exp_pc + 32'd4);
    endtask

    task automatic check_zero(input string tag);
        chk32({tag, ".ctrl"}, {14'd0, RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, BranchE,
                               ALUControlE, RD_E, RS1_E, RS2_E}, 32'd0);
        chk32({tag, ".rd1"}, RD1_E, 32'd0);
        chk32({tag, ".rd2"}, RD2_E, 32'd0);
        chk32({tag, ".imm"}, Imm_Ext_E, 32'd0);
        chk32({tag, ".pc"}, PCE, 32'd0);
        chk32({tag, ".pc4"}, PCPlus4E, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic        fl, wen;
        logic [4:0]  wrd;
        logic [31:0] wd;
        int          k;
        logic [6:0]  ops [5];

        // Reset held with a live instruction: nothing may be captured
        rst = 1'b0; InstrD = 32'h0050_0093; PCD = 32'h40; PCPlus4D = 32'h44;
        FlushE = 1'b0; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
        for (int i = 0; i < 32; i++) mdl_rf[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int r = 1; r < 32; r++) begin
            drive({7'd0, r[4:0], r[4:0], 3'd0, 5'd0, 7'h33}, 1'b0, 1'b0, 5'd0, 32'd0);
            chk32("rf_clear", RD1_E | RD2_E, 32'd0);
        end

        vecs.push_back(mk(32'h0050_0093, 1'b0, 5'b10100, 3'd0, 32'd5,          1'b1, 5'd1));
        vecs.push_back(mk(32'hFE20_AE23, 1'b0, 5'b01100, 3'd0, 32'hFFFF_FFFC, 1'b1, 5'd28));
        vecs.push_back(mk(32'hFE20_8CE3, 1'b0, 5'b00001, 3'd1, 32'hFFFF_FFF8, 1'b1, 5'd25));
        vecs.push_back(mk(32'h0031_8233, 1'b0, 5'b10000, 3'd0, 32'd0,          1'b0, 5'd4));
        vecs.push_back(mk(32'h4020_82B3, 1'b0, 5'b10000, 3'd1, 32'd0,          1'b0, 5'd5));
        vecs.push_back(mk(32'h0081_2303, 1'b0, 5'b10110, 3'd0, 32'd8,          1'b1, 5'd6));
        vecs.push_back(mk(32'h0020_A3B3, 1'b0, 5'b10000, 3'd5, 32'd0,          1'b0, 5'd7));
        vecs.push_back(mk(32'h0020_E433, 1'b0, 5'b10000, 3'd3, 32'd0,          1'b0, 5'd8));
        vecs.push_back(mk(32'h0020_F4B3, 1'b0, 5'b10000, 3'd2, 32'd0,          1'b0, 5'd9));
        vecs.push_back(mk(32'h0020_C533, 1'b0, 5'b10000, 3'd0, 32'd0,          1'b0, 5'd10));
        vecs.push_back(mk(32'hFFFF_FFFF, 1'b0, 5'b00000, 3'd0, 32'hFFFF_FFFF, 1'b1, 5'd31));
        vecs.push_back(mk(32'h0081_2303, 1'b1, 5'b00100, 3'd0, 32'd8,          1'b1, 5'd0));
        vecs.push_back(mk(32'h4000_0093, 1'b0, 5'b10100, 3'd0, 32'h0000_0400, 1'b1, 5'd1));
        foreach (vecs[v]) begin
            drive(vecs[v].instr, vecs[v].flush, 1'b0, 5'd0, 32'd0);
            check_all($sformatf("vec%0d", v), vecs[v].e);
        end

        // Same-cycle writeback of x3 while decoding add x4,x3,x3
        drive(32'h0031_8233, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
`ifdef REGFILE_BYPASS_EN
        chk32("wb_same_rd1", RD1_E, 32'hDEAD_BEEF);
        chk32("wb_same_rd2", RD2_E, 32'hDEAD_BEEF);
`else
        chk32("wb_same_rd1", RD1_E, 32'd0);
        chk32("wb_same_rd2", RD2_E, 32'd0);
`endif
        drive(32'h0031_8233, 1'b0, 1'b0, 5'd0, 32'd0);
        chk32("wb_next_rd1", RD1_E, 32'hDEAD_BEEF);

        // Write to x0 is discarded
        drive(32'h0000_0033, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
        chk32("x0_same", RD1_E, 32'd0);
        drive(32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'd0);
        chk32("x0_next", RD1_E | RD2_E, 32'd0);

        // Flush does not block writeback
        drive(32'h0081_2303, 1'b1, 1'b1, 5'd5, 32'hCAFE_0005);
        chk32("flush_wb.rd", {27'd0, RD_E}, 32'd0);
        chk32("flush_wb.pc", PCE, exp_pc);
        drive(32'h0052_8033, 1'b0, 1'b0, 5'd0, 32'd0);
        chk32("flush_wb.x5", RD1_E, 32'hCAFE_0005);

        // Asynchronous reset mid-pipeline, between clock edges
        drive(32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
        #2 rst = 1'b0;
        #1;
        check_zero("async_rst");
        for (int i = 0; i < 32; i++) mdl_rf[i] = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0052_8033, 1'b0, 1'b0, 5'd0, 32'd0);
        chk32("async_rst.x5", RD1_E, 32'd0);

        // Random traffic against the reference model
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13; ops[4] = 7'h63;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            k = $urandom_range(0, 5);
            if (k < 5) ins[6:0] = ops[k];
            wen = 1'($urandom_range(0, 1));
            wrd = 5'($urandom_range(0, 31));
            wd  = $urandom;
            fl  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) ins[19:15] = wrd;
            if ($urandom_range(0, 2) == 0) ins[24:20] = wrd;
            drive(ins, fl, wen, wrd, wd);
            check_all("rand", model(ins, fl));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
